// File: rtl/fifo_frame_writer.sv
// ---------------------------------------------------------------------------
// fifo_frame_writer
//
// Write-side framer for an async FIFO. Takes an upstream valid/ready word
// stream and writes each frame into the FIFO as:
//     header  {1,0,seq}          rolling sequence number (DSIZE-2 bits)
//     payload {0,s_data}         one FIFO word per upstream word
//     trailer {1,1,chk}          XOR of folded payload words (optional)
// This block is the only agent that drives the FIFO write port.
//
// Optional feature macro: FIFO_FRAME_TRAILER_EN
//     defined   : frames end with a checksum trailer (TRL state, chk register)
//     undefined : frames are header + payload only; frm_cnt counts on the
//                 commit of the s_last payload word
//
// Parameters
//     DSIZE    FIFO word width (>= 4). Payload is DSIZE-1 bits.
//     CNTW     width of the completed-frame counter
//
// Ports
//     wclk      in   write-domain clock, rising edge
//     dirclr_n  in   asynchronous active-low reset
//     s_valid   in   upstream word valid (held until accepted)
//     s_ready   out  upstream word accepted when s_valid && s_ready at an edge
//     s_data    in   payload word [DSIZE-2:0]
//     s_last    in   final payload word of the frame
//     wfull     in   FIFO full, sampled at wclk
//     winc      out  FIFO write request
//     wdata     out  FIFO write word [DSIZE-1:0]
//     busy      out  high whenever the framer is not idle
//     frm_cnt   out  completed-frame count [CNTW-1:0], wraps
// ---------------------------------------------------------------------------
module fifo_frame_writer #(
    parameter int DSIZE = 8,
    parameter int CNTW  = 16
) (
    input  logic             wclk,
    input  logic             dirclr_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DSIZE-2:0] s_data,
    input  logic             s_last,
    input  logic             wfull,
    output logic             winc,
    output logic [DSIZE-1:0] wdata,
    output logic             busy,
    output logic [CNTW-1:0]  frm_cnt
);

    // Width of the sequence and checksum fields.
    localparam int FW = DSIZE - 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PAY  = 2'd1
`ifdef FIFO_FRAME_TRAILER_EN
        ,
        ST_TRL  = 2'd2
`endif
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [FW-1:0]     seq_reg;
    logic [FW-1:0]     seq_next;
    logic [CNTW-1:0]   frm_cnt_reg;
    logic [CNTW-1:0]   frm_cnt_next;

    // Raw (pre-reset-gating) values of the combinational outputs.
    logic              winc_int;
    logic [DSIZE-1:0]  wdata_int;
    logic              s_ready_int;

    // Upstream word present and FIFO able to take it. In IDLE and PAY the
    // FIFO write request is s_valid, so this is exactly the commit condition
    // for those states.
    logic              take;
    assign take = s_valid && !wfull;

`ifdef FIFO_FRAME_TRAILER_EN
    logic [FW-1:0]     chk_reg;
    logic [FW-1:0]     chk_next;
    logic [FW-1:0]     fold_val;

    // fold(d): the low FW bits of the payload with the top payload bit
    // XORed into bit 0, so every payload bit contributes to the checksum.
    genvar gi;
    generate
        for (gi = 0; gi < FW; gi++) begin : g_fold
            if (gi == 0) begin : g_lsb
                assign fold_val[gi] = s_data[gi] ^ s_data[DSIZE-2];
            end else begin : g_mid
                assign fold_val[gi] = s_data[gi];
            end
        end
    endgenerate
`endif

    // -----------------------------------------------------------------------
    // State register. Every piece of state advances only on a FIFO commit,
    // which is folded into the next-state logic below.
    // -----------------------------------------------------------------------
    always_ff @(posedge wclk or negedge dirclr_n) begin
        if (!dirclr_n) begin
            state_reg   <= ST_IDLE;
            seq_reg     <= '0;
            frm_cnt_reg <= '0;
`ifdef FIFO_FRAME_TRAILER_EN
            chk_reg     <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            seq_reg     <= seq_next;
            frm_cnt_reg <= frm_cnt_next;
`ifdef FIFO_FRAME_TRAILER_EN
            chk_reg     <= chk_next;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output decode.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        seq_next     = seq_reg;
        frm_cnt_next = frm_cnt_reg;
`ifdef FIFO_FRAME_TRAILER_EN
        chk_next     = chk_reg;
`endif
        winc_int     = 1'b0;
        wdata_int    = '0;
        s_ready_int  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // The header is offered as soon as the first payload word
                // shows up; the payload itself is not consumed here.
                winc_int  = s_valid;
                wdata_int = {2'b10, seq_reg};
                if (take) begin
                    state_next = ST_PAY;
                    seq_next   = seq_reg + 1'b1;
`ifdef FIFO_FRAME_TRAILER_EN
                    chk_next   = '0;
`endif
                end
            end

            ST_PAY: begin
                winc_int    = s_valid;
                wdata_int   = {1'b0, s_data};
                s_ready_int = !wfull;
                if (take) begin
`ifdef FIFO_FRAME_TRAILER_EN
                    chk_next = chk_reg ^ fold_val;
                    if (s_last) begin
                        state_next = ST_TRL;
                    end
`else
                    if (s_last) begin
                        state_next   = ST_IDLE;
                        frm_cnt_next = frm_cnt_reg + 1'b1;
                    end
`endif
                end
            end

`ifdef FIFO_FRAME_TRAILER_EN
            ST_TRL: begin
                // chk already includes the last payload word (folded in on
                // its commit), so the trailer is formed from chk_reg alone.
                winc_int  = 1'b1;
                wdata_int = {2'b11, chk_reg};
                if (!wfull) begin
                    state_next   = ST_IDLE;
                    frm_cnt_next = frm_cnt_reg + 1'b1;
                end
            end
`endif

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs. While reset is held the FIFO port is forced quiet, even if
    // upstream keeps s_valid high, so no stray word can be committed.
    // -----------------------------------------------------------------------
    assign winc    = dirclr_n & winc_int;
    assign wdata   = dirclr_n ? wdata_int : '0;
    assign s_ready = dirclr_n & s_ready_int;
    assign busy    = dirclr_n && (state_reg != ST_IDLE);
    assign frm_cnt = frm_cnt_reg;

endmodule
